wb_burst_master: RTL and testbench

Wishbone B4 initiator that drives the slave port of the SDRAM controller (`sdrc_top`) with incrementing bursts. It accepts one command at a time: an address, a beat count, a direction and a data seed. It then runs a single wishbone cycle of that many beats. Write data is generated from the seed; read data is checked against the same pattern, and mismatches are counted. It is the initiator end of the controller's wishbone interface, used as a traffic and self-check engine next to the controller.

---
 rtl/wb_burst_master.sv | 132 +++++++++++++
 tb/tb_wb_burst_master.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_master.sv
// Wishbone B4 burst initiator: runs one incrementing burst per command, generating
// write data from a seed and counting read-back mismatches against the same pattern.
module wb_burst_master #(
  parameter int APP_AW  = 26,
  parameter int SDR_DW  = 32,
  parameter int SDR_BW  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              sys_clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [APP_AW-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic [SDR_DW-1:0] cmd_seed,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [APP_AW-1:0] wb_addr_o,
  output logic [SDR_DW-1:0] wb_dat_o,
  output logic [SDR_BW-1:0] wb_sel_o,
  output logic [2:0]        wb_cti_o,
  input  logic              wb_ack_i,
  input  logic [SDR_DW-1:0] wb_dat_i,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [15:0]       err_cnt
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, XFER, FIN} state_t;

  state_t            state, state_nxt;
  logic [APP_AW-1:0] addr_r;
  logic [7:0]        len_r;
  logic              write_r;
  logic [SDR_DW-1:0] seed_r;
  logic [7:0]        idx;
  logic [WDW-1:0]    wdog;

  logic              accept;
  logic              last_beat;
  logic              wd_expire;
  logic              beat_ack;
  logic [SDR_DW-1:0] beat_dat;
  logic [APP_AW-1:0] beat_addr;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign accept    = cmd_valid && (state == IDLE);
  assign beat_ack  = (state == XFER) && wb_ack_i;
  assign beat_dat  = seed_r + SDR_DW'(idx);
  assign beat_addr = addr_r + APP_AW'(idx) * APP_AW'(SDR_BW);
  assign last_beat = (idx == len_r - 8'd1);
  assign wd_expire = !wb_ack_i && (wdog == WDW'(TIMEOUT - 1));

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

  // Bus outputs decode from state only, so an async reset clears them at once.
  always_comb begin
    state_nxt = state;
    wb_cyc_o  = 1'b0;
    wb_stb_o  = 1'b0;
    wb_we_o   = 1'b0;
    wb_addr_o = '0;
    wb_dat_o  = '0;
    wb_sel_o  = '0;
    wb_cti_o  = 3'b000;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (cmd_len == 8'd0) ? FIN : XFER;
      end
      XFER: begin
        wb_cyc_o  = 1'b1;
        wb_stb_o  = 1'b1;
        wb_we_o   = write_r;
        wb_addr_o = beat_addr;
        wb_dat_o  = write_r ? beat_dat : '0;
        wb_sel_o  = '1;
        wb_cti_o  = last_beat ? 3'b111 : 3'b010;
        if ((wb_ack_i && last_beat) || wd_expire) state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      idx     <= 8'd0;
      wdog    <= '0;
      timeout <= 1'b0;
      err_cnt <= 16'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx     <= 8'd0;
        wdog    <= '0;
        timeout <= 1'b0;
        if (!cmd_write) err_cnt <= 16'd0;
      end else if (state == XFER) begin
        if (wb_ack_i) begin
          idx  <= idx + 8'd1;
          wdog <= '0;
        end else begin
          wdog <= wdog + WDW'(1);
        end
        if (wd_expire) timeout <= 1'b1;
        if (beat_ack && !write_r && (wb_dat_i != beat_dat)) err_cnt <= sat_inc16(err_cnt);
      end
    end
  end

  // Command fields only matter while busy, so they carry no reset.
  always_ff @(posedge sys_clk) begin
    if (accept) begin
      addr_r  <= cmd_addr;
      len_r   <= cmd_len;
      write_r <= cmd_write;
      seed_r  <= cmd_seed;
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master with a small memory-backed wishbone slave.
module tb_wb_burst_master;

  logic        sys_clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [25:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [31:0] cmd_seed = '0;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [25:0] wb_addr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic        wb_ack_i;
  logic [31:0] wb_dat_i;
  logic        busy, done, timeout;
  logic [15:0] err_cnt;

  int checks = 0;
  int errors = 0;

  logic        ack_zero = 1'b0;
  logic        ack_wait = 1'b0;
  logic        ack_r = 1'b0;
  logic        corrupt = 1'b0;
  logic [25:0] corrupt_addr = '0;
  logic [31:0] mem [0:255];

  wb_burst_master #(.APP_AW(26), .SDR_DW(32), .SDR_BW(4), .TIMEOUT(16)) dut (
    .sys_clk(sys_clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_seed(cmd_seed),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i),
    .busy(busy), .done(done), .timeout(timeout), .err_cnt(err_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  // Slave: zero-wait ack, or one wait state per beat; word memory indexed by addr[9:2].
  assign wb_ack_i = wb_stb_o && (ack_zero || (ack_wait && ack_r));
  assign wb_dat_i = (corrupt && wb_addr_o == corrupt_addr) ? 32'hDEADBEEF : mem[wb_addr_o[9:2]];

  always @(posedge sys_clk) begin
    ack_r <= ack_wait && wb_stb_o && !ack_r;
    if (wb_cyc_o && wb_stb_o && wb_we_o && wb_ack_i) mem[wb_addr_o[9:2]] <= wb_dat_o;
  end

  task automatic issue(input logic we, input logic [25:0] a, input logic [7:0] l,
                       input logic [31:0] s);
    cmd_write = we; cmd_addr = a; cmd_len = l; cmd_seed = s; cmd_valid = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge sys_clk);
    checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o, wb_addr_o, wb_dat_o} !== 68'd0) begin
      errors++;
      $display("FAIL reset_wb: got %h exp 0",
               {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o, wb_addr_o, wb_dat_o});
    end
    checks++;
    if ({cmd_ready, busy, done, timeout, err_cnt} !== {1'b1, 3'b000, 16'd0}) begin
      errors++;
      $display("FAIL reset_ctl: got %h exp %h", {cmd_ready, busy, done, timeout, err_cnt},
               {1'b1, 3'b000, 16'd0});
    end
    resetn = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_write_burst();
    logic [25:0] ea;
    logic [31:0] ed;
    logic [2:0]  ec;
    ack_zero = 1'b1;
    issue(1'b1, 26'h100, 8'd4, 32'hA5A50000);
    for (int b = 0; b < 4; b++) begin
      ea = 26'h100 + 26'(4 * b);
      ed = 32'hA5A50000 + 32'(b);
      ec = (b == 3) ? 3'b111 : 3'b010;
      checks++;
      if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o} !== {3'b111, 4'hF, ec}) begin
        errors++;
        $display("FAIL wr_ctl beat%0d: got %b exp %b", b,
                 {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o}, {3'b111, 4'hF, ec});
      end
      checks++;
      if (wb_addr_o !== ea || wb_dat_o !== ed) begin
        errors++;
        $display("FAIL wr_addr_dat beat%0d: got %h/%h exp %h/%h", b, wb_addr_o, wb_dat_o, ea, ed);
      end
      @(negedge sys_clk);
    end
    checks++;
    if ({wb_cyc_o, done, cmd_ready} !== 3'b010) begin
      errors++;
      $display("FAIL wr_fin: cyc/done/ready got %b exp 010", {wb_cyc_o, done, cmd_ready});
    end
    @(negedge sys_clk);
    checks++;
    if ({wb_cyc_o, done, cmd_ready} !== 3'b001) begin
      errors++;
      $display("FAIL wr_idle: cyc/done/ready got %b exp 001", {wb_cyc_o, done, cmd_ready});
    end
  endtask

  task automatic test_read_waits();
    int pulses;
    ack_zero = 1'b0;
    ack_wait = 1'b1;
    pulses = 0;
    issue(1'b0, 26'h100, 8'd4, 32'hA5A50000);
    for (int c = 0; c < 20; c++) begin
      if (done) pulses++;
      @(negedge sys_clk);
    end
    ack_wait = 1'b0;
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL rd_wait_done: got %0d pulses exp 1", pulses);
    end
    checks++;
    if ({err_cnt, timeout, cmd_ready} !== {16'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rd_wait_status: err/to/ready got %h exp %h", {err_cnt, timeout, cmd_ready},
               {16'd0, 1'b0, 1'b1});
    end
  endtask

  task automatic test_err_timing();
    bit ok;
    ack_zero = 1'b1;
    issue(1'b0, 26'h100, 8'd4, 32'hA5A50001);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (err_cnt !== 16'(c)) begin
        errors++;
        $display("FAIL err_step cycle%0d: got %0d exp %0d", c + 1, err_cnt, c);
      end
      @(negedge sys_clk);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL err_step_ready: got %b exp 1", cmd_ready);
    end
    wait_done(ok);
  endtask

  task automatic test_corrupt();
    bit ok;
    ack_zero = 1'b1;
    issue(1'b1, 26'h200, 8'd8, 32'h12340000);
    wait_done(ok);
    corrupt = 1'b1;
    corrupt_addr = 26'h208;
    issue(1'b0, 26'h200, 8'd8, 32'h12340000);
    wait_done(ok);
    corrupt = 1'b0;
    checks++;
    if (!ok || err_cnt !== 16'd1) begin
      errors++;
      $display("FAIL corrupt_read: done=%b err_cnt got %0d exp 1", ok, err_cnt);
    end
    issue(1'b1, 26'h300, 8'd2, 32'h0);
    wait_done(ok);
    checks++;
    if (err_cnt !== 16'd1) begin
      errors++;
      $display("FAIL corrupt_after_write: got %0d exp 1", err_cnt);
    end
    issue(1'b0, 26'h200, 8'd8, 32'h12340000);
    wait_done(ok);
    checks++;
    if (!ok || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL corrupt_clear: done=%b err_cnt got %0d exp 0", ok, err_cnt);
    end
  endtask

  task automatic test_watchdog();
    int n;
    ack_zero = 1'b0;
    issue(1'b1, 26'h40, 8'd3, 32'h0);
    n = 0;
    while (wb_cyc_o && n < 40) begin
      n++;
      @(negedge sys_clk);
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL wdog_len: cyc high got %0d cycles exp 16", n);
    end
    checks++;
    if ({wb_cyc_o, wb_stb_o, done, timeout} !== 4'b0011) begin
      errors++;
      $display("FAIL wdog_abort: cyc/stb/done/to got %b exp 0011",
               {wb_cyc_o, wb_stb_o, done, timeout});
    end
    @(negedge sys_clk);
    checks++;
    if ({cmd_ready, timeout} !== 2'b11) begin
      errors++;
      $display("FAIL wdog_sticky: ready/to got %b exp 11", {cmd_ready, timeout});
    end
    issue(1'b1, 26'h0, 8'd0, 32'h0);
    checks++;
    if ({timeout, done} !== 2'b01) begin
      errors++;
      $display("FAIL wdog_clear: to/done got %b exp 01", {timeout, done});
    end
    @(negedge sys_clk);
  endtask

  task automatic test_zero_len();
    issue(1'b1, 26'h100, 8'd0, 32'h0);
    checks++;
    if ({wb_cyc_o, wb_stb_o, done, busy, cmd_ready} !== 5'b00110) begin
      errors++;
      $display("FAIL zlen_n1: cyc/stb/done/busy/ready got %b exp 00110",
               {wb_cyc_o, wb_stb_o, done, busy, cmd_ready});
    end
    @(negedge sys_clk);
    checks++;
    if ({wb_cyc_o, done, cmd_ready} !== 3'b001) begin
      errors++;
      $display("FAIL zlen_n2: cyc/done/ready got %b exp 001", {wb_cyc_o, done, cmd_ready});
    end
  endtask

  task automatic test_len1();
    ack_zero = 1'b1;
    issue(1'b0, 26'h100, 8'd1, 32'hA5A50000);
    checks++;
    if ({wb_cyc_o, wb_we_o, wb_cti_o, wb_addr_o, wb_dat_o} !== {2'b10, 3'b111, 26'h100, 32'h0}) begin
      errors++;
      $display("FAIL len1_beat: got %h exp %h", {wb_cyc_o, wb_we_o, wb_cti_o, wb_addr_o, wb_dat_o},
               {2'b10, 3'b111, 26'h100, 32'h0});
    end
    @(negedge sys_clk);
    checks++;
    if ({wb_cyc_o, done, err_cnt} !== {2'b01, 16'd0}) begin
      errors++;
      $display("FAIL len1_fin: cyc/done/err got %h exp %h", {wb_cyc_o, done, err_cnt},
               {2'b01, 16'd0});
    end
    @(negedge sys_clk);
  endtask

  task automatic test_addr_wrap();
    bit ok;
    ack_zero = 1'b1;
    issue(1'b1, 26'h3FFFFFC, 8'd2, 32'h55);
    checks++;
    if ({wb_addr_o, wb_dat_o, wb_cti_o} !== {26'h3FFFFFC, 32'h55, 3'b010}) begin
      errors++;
      $display("FAIL wrap_beat0: got %h exp %h", {wb_addr_o, wb_dat_o, wb_cti_o},
               {26'h3FFFFFC, 32'h55, 3'b010});
    end
    @(negedge sys_clk);
    checks++;
    if ({wb_addr_o, wb_dat_o, wb_cti_o} !== {26'h0, 32'h56, 3'b111}) begin
      errors++;
      $display("FAIL wrap_beat1: got %h exp %h", {wb_addr_o, wb_dat_o, wb_cti_o},
               {26'h0, 32'h56, 3'b111});
    end
    wait_done(ok);
  endtask

  task automatic test_reset_mid();
    bit ok;
    ack_zero = 1'b1;
    issue(1'b1, 26'h100, 8'd8, 32'hA5A50000);
    repeat (2) @(negedge sys_clk);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o, wb_addr_o, wb_dat_o} !== 68'd0) begin
      errors++;
      $display("FAIL rstmid_wb: got %h exp 0",
               {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o, wb_addr_o, wb_dat_o});
    end
    @(negedge sys_clk);
    resetn = 1'b1;
    @(negedge sys_clk);
    checks++;
    if ({cmd_ready, busy, wb_cyc_o} !== 3'b100) begin
      errors++;
      $display("FAIL rstmid_ready: ready/busy/cyc got %b exp 100", {cmd_ready, busy, wb_cyc_o});
    end
    issue(1'b1, 26'h100, 8'd2, 32'hA5A50000);
    checks++;
    if ({wb_cyc_o, wb_addr_o, wb_dat_o, wb_cti_o} !== {1'b1, 26'h100, 32'hA5A50000, 3'b010}) begin
      errors++;
      $display("FAIL rstmid_beat0: got %h exp %h", {wb_cyc_o, wb_addr_o, wb_dat_o, wb_cti_o},
               {1'b1, 26'h100, 32'hA5A50000, 3'b010});
    end
    @(negedge sys_clk);
    checks++;
    if ({wb_cyc_o, wb_addr_o, wb_dat_o, wb_cti_o} !== {1'b1, 26'h104, 32'hA5A50001, 3'b111}) begin
      errors++;
      $display("FAIL rstmid_beat1: got %h exp %h", {wb_cyc_o, wb_addr_o, wb_dat_o, wb_cti_o},
               {1'b1, 26'h104, 32'hA5A50001, 3'b111});
    end
    wait_done(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rstmid_done: got 0 exp 1");
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    ack_zero = 1'b1;
    cmd_write = 1'b1; cmd_addr = 26'h180; cmd_len = 8'd2; cmd_seed = 32'h77;
    cmd_valid = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if ({wb_cyc_o, wb_addr_o} !== {1'b1, 26'h180}) begin
      errors++;
      $display("FAIL b2b_first: got %h exp %h", {wb_cyc_o, wb_addr_o}, {1'b1, 26'h180});
    end
    repeat (2) @(negedge sys_clk);
    checks++;
    if ({wb_cyc_o, done, cmd_ready} !== 3'b010) begin
      errors++;
      $display("FAIL b2b_fin: cyc/done/ready got %b exp 010", {wb_cyc_o, done, cmd_ready});
    end
    @(negedge sys_clk);
    checks++;
    if ({wb_cyc_o, done, cmd_ready} !== 3'b001) begin
      errors++;
      $display("FAIL b2b_idle: cyc/done/ready got %b exp 001", {wb_cyc_o, done, cmd_ready});
    end
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    checks++;
    if ({wb_cyc_o, wb_addr_o, wb_dat_o} !== {1'b1, 26'h180, 32'h77}) begin
      errors++;
      $display("FAIL b2b_second: got %h exp %h", {wb_cyc_o, wb_addr_o, wb_dat_o},
               {1'b1, 26'h180, 32'h77});
    end
    wait_done(ok);
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_waits();
    test_err_timing();
    test_corrupt();
    test_watchdog();
    test_zero_len();
    test_len1();
    test_addr_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
